ball_event_detector: RTL and testbench
======================================

// Module: ball_event_detector
// PURPOSE
// Produces ball-motion events consumed by ball_move: collision with zone code (X_direction/Y_direction),
// goal, doubleball. Accumulates pixel-level overlaps between ball and other objects over one video frame,
// then issues one-cycle event pulses at frame start. Also keeps per-side score and game-over state.
// Sits between the VGA drawing-request muxes and ball_move.
// PARAMETERS
// PLAYER_H        30  player sprite height in pixels; zone thirds derived from it
// WIN_SCORE       5   goals needed to end the game (1..15)
// GOAL_HOLD_FRM   60  frames after a goal during which no events are issued
// COLL_GAP_FRM    4   minimum frames between two collision pulses
// PORTS
// CLK            in   1   system clock (pixel clock domain)
// RESETn         in   1   asynchronous active-low reset
// startOfFrame   in   1   one-cycle pulse, first cycle of each frame
// move           in   1   game running (level, same signal ball_move receives)
// ball_dr        in   1   ball drawing request at current pixel
// player_dr      in   1   any player drawing request at current pixel
// player_offY    in   6   row offset of current pixel inside the player sprite (0..PLAYER_H-1)
// goalL_dr       in   1   left goal area drawing request
// goalR_dr       in   1   right goal area drawing request
// bonus_dr       in   1   double-ball bonus object drawing request
// collision      out  1   one-cycle pulse: ball hit a player
// X_direction    out  1   zone code bit, valid with collision, held otherwise
// Y_direction    out  1   zone code bit, valid with collision, held otherwise
// goal           out  1   one-cycle pulse: goal scored
// doubleball     out  1   one-cycle pulse: ball hit bonus object
// scoreL         out  4   goals scored into right goal by left team
// scoreR         out  4   goals scored into left goal by right team
// game_over      out  1   level: a side reached WIN_SCORE
// BEHAVIOUR
// - Reset: all outputs 0, all sticky flags clear, counters 0, state IDLE.
// - Sticky flags (per frame): hitP = ball_dr&player_dr, hitGL = ball_dr&goalL_dr, hitGR = ball_dr&goalR_dr,
//   hitB = ball_dr&bonus_dr. Overlap on the startOfFrame cycle belongs to the new frame.
// - Zone: player_offY latched on the first hitP pixel of the frame only (topmost in raster order).
//   off < PLAYER_H/3 -> {Y,X}=10 (upper); off < 2*PLAYER_H/3 -> 00 (middle, straight); else 11 (lower).
// - Evaluation: on startOfFrame, flags of ended frame are evaluated; pulse outputs high the NEXT cycle,
//   exactly one cycle; flags cleared in the same cycle they are evaluated.
// - Priority within a frame: goal > collision > doubleball; only one pulse per frame.
// - hitGL and hitGR both set: goal to the side whose flag was set first; same cycle -> no goal.
// - FSM: IDLE -> PLAY on move rising edge (scores cleared to 0, counters cleared).
//   PLAY: evaluate events. goal -> increment scorer, GOAL_HOLD. PLAY -> IDLE when move=0.
//   GOAL_HOLD: count GOAL_HOLD_FRM frames, no pulses, flags still cleared each frame; then PLAY,
//   or OVER if a score equals WIN_SCORE. OVER: game_over=1, scores frozen; move rising edge -> PLAY
//   with scores 0 and game_over=0.
// - Collision gap: after a collision pulse, hitP ignored for COLL_GAP_FRM frames (counter per frame).
// - Scores 4-bit, never exceed WIN_SCORE (no wrap).
// - move falling mid-frame: flags cleared, counters cleared, no pulse at next frame start.
// - X_direction/Y_direction change only when collision pulses.
// STRUCTURE
// - foosball_pkg: typedef enum {IDLE,PLAY,GOAL_HOLD,OVER} game_state_t; typedef logic[1:0] hit_zone_t
//   with ZONE_UP=2'b10, ZONE_MID=2'b00, ZONE_LOW=2'b11; shared PLAYER_H default.
// - One sub-module: frame_hit_latch (sticky OR flag + first-hit capture, cleared on startOfFrame);
//   instantiated per event source. Frame counters and FSM in top.
// TESTING
// - Reset, move 0->1, frame with ball_dr&player_dr at offY=3 -> collision=1 one cycle after next SOF, {Y,X}=10.
// - Hits at offY=15 then offY=25 in same frame -> zone 00 (first hit wins); next frame offY=25 ignored (gap).
// - Ball&goalR_dr and ball&player_dr in same frame -> goal pulse only, scoreL 0->1, no events for 60 frames.
// - Five left goals -> scoreL=5, game_over=1, further overlaps give no pulses; move toggle -> scores 0.
// - bonus overlap only -> doubleball pulse one cycle; move dropped mid-frame after hit -> no pulse.
// - RESETn asserted mid-GOAL_HOLD -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/foosball_pkg.sv
// Shared types and helpers for the foosball ball-event path.
package foosball_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GOAL_HOLD, OVER} game_state_t;

  typedef logic [1:0] hit_zone_t;
  localparam hit_zone_t ZONE_UP  = 2'b10;
  localparam hit_zone_t ZONE_MID = 2'b00;
  localparam hit_zone_t ZONE_LOW = 2'b11;

  localparam int unsigned PLAYER_H_DEF = 30;

  // Splits the player sprite into thirds; the row offset selects the bounce zone.
  function automatic hit_zone_t zone_of(input logic [5:0] off, input int unsigned player_h);
    if (32'(off) < player_h / 3) return ZONE_UP;
    if (32'(off) < (2 * player_h) / 3) return ZONE_MID;
    return ZONE_LOW;
  endfunction

endpackage

// File: rtl/frame_hit_latch.sv
// Per-frame sticky overlap flag with capture of side data on the first hit of the frame.
module frame_hit_latch #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sof,
  input  logic         clr,
  input  logic         hit,
  input  logic [W-1:0] data_in,
  output logic         flag,
  output logic [W-1:0] data
);

  logic         flag_q, flag_d;
  logic [W-1:0] data_q, data_d;

  // A hit on the start-of-frame cycle opens the new frame rather than closing the old one.
  always_comb begin
    flag_d = flag_q;
    data_d = data_q;
    if (clr) begin
      flag_d = 1'b0;
      data_d = '0;
    end else if (sof) begin
      flag_d = hit;
      if (hit) data_d = data_in;
    end else begin
      flag_d = flag_q | hit;
      if (hit && !flag_q) data_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      data_q <= '0;
    end else begin
      flag_q <= flag_d;
      data_q <= data_d;
    end
  end

  assign flag = flag_q;
  assign data = data_q;

endmodule

// File: rtl/ball_event_detector.sv
// Collects per-frame ball overlaps and emits collision/goal/doubleball pulses at frame start;
// also tracks the score and game-over state.
module ball_event_detector
  import foosball_pkg::*;
#(
  parameter int unsigned PLAYER_H      = PLAYER_H_DEF,
  parameter int unsigned WIN_SCORE     = 5,
  parameter int unsigned GOAL_HOLD_FRM = 60,
  parameter int unsigned COLL_GAP_FRM  = 4
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       startOfFrame,
  input  logic       move,
  input  logic       ball_dr,
  input  logic       player_dr,
  input  logic [5:0] player_offY,
  input  logic       goalL_dr,
  input  logic       goalR_dr,
  input  logic       bonus_dr,
  output logic       collision,
  output logic       X_direction,
  output logic       Y_direction,
  output logic       goal,
  output logic       doubleball,
  output logic [3:0] scoreL,
  output logic [3:0] scoreR,
  output logic       game_over
);

  localparam int unsigned HOLD_W = $clog2(GOAL_HOLD_FRM + 2);
  localparam int unsigned GAP_W  = $clog2(COLL_GAP_FRM + 2);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);

  logic       p_f, gl_f, gr_f, b_f;
  logic [5:0] p_off;
  logic       gl_late, gr_late, b_data_unused;
  logic       gl_hit, gr_hit;

  assign gl_hit = ball_dr & goalL_dr;
  assign gr_hit = ball_dr & goalR_dr;

  // Goal latches record whether the other goal was already (or simultaneously) hit.
  frame_hit_latch #(.W(6)) u_hit_p (
    .clk(CLK), .rst_n(RESETn), .sof(startOfFrame), .clr(~move),
    .hit(ball_dr & player_dr), .data_in(player_offY), .flag(p_f), .data(p_off));
  frame_hit_latch #(.W(1)) u_hit_gl (
    .clk(CLK), .rst_n(RESETn), .sof(startOfFrame), .clr(~move),
    .hit(gl_hit), .data_in((gr_f & ~startOfFrame) | gr_hit), .flag(gl_f), .data(gl_late));
  frame_hit_latch #(.W(1)) u_hit_gr (
    .clk(CLK), .rst_n(RESETn), .sof(startOfFrame), .clr(~move),
    .hit(gr_hit), .data_in((gl_f & ~startOfFrame) | gl_hit), .flag(gr_f), .data(gr_late));
  frame_hit_latch #(.W(1)) u_hit_b (
    .clk(CLK), .rst_n(RESETn), .sof(startOfFrame), .clr(~move),
    .hit(ball_dr & bonus_dr), .data_in(1'b0), .flag(b_f), .data(b_data_unused));

  game_state_t       state_q, state_d;
  logic              move_q, move_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  hit_zone_t         zone_q, zone_d;
  logic              collision_q, collision_d, goal_q, goal_d, db_q, db_d;
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic              game_over_q, game_over_d;

  logic move_rise, gl_win, gr_win, p_eff;

  assign move_rise = move & ~move_q;
  assign gl_win    = gl_f & (~gr_f | ~gl_late);
  assign gr_win    = gr_f & (~gl_f | ~gr_late);
  assign p_eff     = p_f & (gap_q == '0);

  always_comb begin
    state_d     = state_q;
    move_d      = move;
    hold_d      = hold_q;
    gap_d       = gap_q;
    zone_d      = zone_q;
    collision_d = 1'b0;
    goal_d      = 1'b0;
    db_d        = 1'b0;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    case (state_q)
      IDLE, OVER: begin
        if (move_rise) begin
          state_d   = PLAY;
          score_l_d = '0;
          score_r_d = '0;
          hold_d    = '0;
          gap_d     = '0;
        end
      end
      PLAY: begin
        if (!move) begin
          state_d = IDLE;
          hold_d  = '0;
          gap_d   = '0;
        end else if (startOfFrame) begin
          if (gap_q != '0) gap_d = gap_q - 1'b1;
          if (gr_win) begin
            goal_d    = 1'b1;
            score_l_d = (score_l_q < WIN) ? score_l_q + 4'd1 : score_l_q;
            state_d   = GOAL_HOLD;
            hold_d    = '0;
          end else if (gl_win) begin
            goal_d    = 1'b1;
            score_r_d = (score_r_q < WIN) ? score_r_q + 4'd1 : score_r_q;
            state_d   = GOAL_HOLD;
            hold_d    = '0;
          end else if (p_eff) begin
            collision_d = 1'b1;
            zone_d      = zone_of(p_off, PLAYER_H);
            gap_d       = GAP_W'(COLL_GAP_FRM);
          end else if (b_f) begin
            db_d = 1'b1;
          end
        end
      end
      GOAL_HOLD: begin
        if (!move) begin
          state_d = IDLE;
          hold_d  = '0;
          gap_d   = '0;
        end else if (startOfFrame) begin
          if (hold_q == HOLD_W'(GOAL_HOLD_FRM - 1)) begin
            hold_d  = '0;
            state_d = (score_l_q == WIN || score_r_q == WIN) ? OVER : PLAY;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      move_q      <= 1'b0;
      hold_q      <= '0;
      gap_q       <= '0;
      zone_q      <= ZONE_MID;
      collision_q <= 1'b0;
      goal_q      <= 1'b0;
      db_q        <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      move_q      <= move_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      zone_q      <= zone_d;
      collision_q <= collision_d;
      goal_q      <= goal_d;
      db_q        <= db_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
    end
  end

  assign collision   = collision_q;
  assign Y_direction = zone_q[1];
  assign X_direction = zone_q[0];
  assign goal        = goal_q;
  assign doubleball  = db_q;
  assign scoreL      = score_l_q;
  assign scoreR      = score_r_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_ball_event_detector.sv
// Self-checking bench for ball_event_detector: frame vectors with scoreboarded event expectations.
module tb_ball_event_detector;

  logic       CLK = 1'b0;
  logic       RESETn, startOfFrame, move, ball_dr, player_dr, goalL_dr, goalR_dr, bonus_dr;
  logic [5:0] player_offY;
  logic       collision, X_direction, Y_direction, goal, doubleball, game_over;
  logic [3:0] scoreL, scoreR;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] UP = 2'b10, MID = 2'b00, LOW = 2'b11;

  typedef struct {
    bit         col;
    logic [1:0] zone;
    bit         goal;
    bit         db;
    int         sl;
    int         sr;
    bit         go;
  } exp_t;

  typedef struct {
    bit         p1;
    logic [5:0] off1;
    bit         p2;
    logic [5:0] off2;
    int         gl_c;
    int         gr_c;
    bit         b;
    bit         b_sof;
    int         drop_c;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  logic sof_prev;

  ball_event_detector #(.PLAYER_H(30), .WIN_SCORE(5), .GOAL_HOLD_FRM(60), .COLL_GAP_FRM(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame), .move(move),
    .ball_dr(ball_dr), .player_dr(player_dr), .player_offY(player_offY),
    .goalL_dr(goalL_dr), .goalR_dr(goalR_dr), .bonus_dr(bonus_dr),
    .collision(collision), .X_direction(X_direction), .Y_direction(Y_direction),
    .goal(goal), .doubleball(doubleball), .scoreL(scoreL), .scoreR(scoreR),
    .game_over(game_over));

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t E(bit col, logic [1:0] z, bit g, bit d, int sl, int sr, bit go);
    exp_t e;
    e.col = col; e.zone = z; e.goal = g; e.db = d; e.sl = sl; e.sr = sr; e.go = go;
    return e;
  endfunction

  function automatic vec_t R(bit p1, int off1, bit p2, int off2, int gl, int gr,
                             bit b, bit bs, int drop, exp_t e);
    vec_t v;
    v.p1 = p1; v.off1 = 6'(off1); v.p2 = p2; v.off2 = 6'(off2);
    v.gl_c = gl; v.gr_c = gr; v.b = b; v.b_sof = bs; v.drop_c = drop; v.e = e;
    return v;
  endfunction

  // Event outputs of a frame appear the cycle after its closing start-of-frame.
  always @(posedge CLK or negedge RESETn)
    if (!RESETn) sof_prev <= 1'b0;
    else         sof_prev <= startOfFrame;

  always @(negedge CLK) begin
    if (RESETn) begin
      if (sof_prev) begin
        chk("sb_nonempty", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("collision", int'(collision), int'(mon_e.col));
          chk("zone_YX", int'({Y_direction, X_direction}), int'(mon_e.zone));
          chk("goal", int'(goal), int'(mon_e.goal));
          chk("doubleball", int'(doubleball), int'(mon_e.db));
          chk("scoreL", int'(scoreL), mon_e.sl);
          chk("scoreR", int'(scoreR), mon_e.sr);
          chk("game_over", int'(game_over), int'(mon_e.go));
        end
      end else begin
        chk("stray_pulse", int'({collision, goal, doubleball}), 0);
      end
    end
  end

  task automatic drive(input bit sof, input bit bl, input bit pl, input logic [5:0] off,
                       input bit gl, input bit gr, input bit bo);
    @(negedge CLK);
    startOfFrame = sof; ball_dr = bl; player_dr = pl; player_offY = off;
    goalL_dr = gl; goalR_dr = gr; bonus_dr = bo;
  endtask

  task automatic set_move(input bit m);
    drive(0, 0, 0, 6'd0, 0, 0, 0);
    move = m;
  endtask

  // Eight pixel cycles, then the start-of-frame that closes this frame.
  task automatic do_frame(input vec_t v);
    for (int c = 1; c <= 8; c++) begin
      bit ph  = (v.p1 && c == 2) || (v.p2 && c == 6);
      bit glh = (v.gl_c == c);
      bit grh = (v.gr_c == c);
      bit bh  = v.b && c == 4;
      logic [5:0] off = (c == 2) ? v.off1 : (c == 6) ? v.off2 : 6'(c);
      if (c == 7) drive(0, 0, 1, off, 1, 1, 1);
      else        drive(0, ph | glh | grh | bh | (c == 1), ph, off, glh, grh, bh);
      if (v.drop_c == c) move = 1'b0;
    end
    drive(1, v.b_sof, 0, 6'd0, 0, 0, v.b_sof);
    sb.push_back(v.e);
  endtask

  task automatic hold_frames(input int sl, input int sr, input logic [1:0] z, input bit last_go);
    for (int f = 1; f <= 60; f++)
      do_frame(R(1, 3, 0, 0, 0, 5, 1, 0, 0, E(0, z, 0, 0, sl, sr, last_go && f == 60)));
  endtask

  initial begin
    RESETn = 1'b1; move = 1'b0; startOfFrame = 1'b0; ball_dr = 1'b0; player_dr = 1'b0;
    player_offY = 6'd0; goalL_dr = 1'b0; goalR_dr = 1'b0; bonus_dr = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    chk("rst_outputs", int'({collision, X_direction, Y_direction, goal, doubleball, game_over}), 0);
    chk("rst_scores", int'({scoreL, scoreR}), 0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;

    do_frame(R(1, 3, 0, 0, 0, 0, 1, 0, 0, E(0, MID, 0, 0, 0, 0, 0)));
    set_move(1);
    do_frame(R(0, 0, 0, 0, 0, 0, 0, 0, 0, E(0, MID, 0, 0, 0, 0, 0)));

    tbl.push_back(R(1,  3, 0,  0, 0, 0, 0, 0, 0, E(1, UP,  0, 0, 0, 0, 0)));
    tbl.push_back(R(1, 25, 0,  0, 0, 0, 1, 0, 0, E(0, UP,  0, 1, 0, 0, 0)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(R(1, 25, 0, 0, 0, 0, 0, 0, 0, E(0, UP, 0, 0, 0, 0, 0)));
    tbl.push_back(R(1, 15, 1, 25, 0, 0, 0, 0, 0, E(1, MID, 0, 0, 0, 0, 0)));
    tbl.push_back(R(1, 25, 0,  0, 0, 0, 0, 0, 0, E(0, MID, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, E(0, MID, 0, 0, 0, 0, 0)));
    tbl.push_back(R(1, 20, 0,  0, 0, 0, 0, 0, 0, E(1, LOW, 0, 0, 0, 0, 0)));
    tbl.push_back(R(1,  9, 0,  0, 0, 0, 0, 0, 0, E(0, LOW, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, E(0, LOW, 0, 0, 0, 0, 0)));
    tbl.push_back(R(1, 10, 0,  0, 0, 0, 0, 0, 0, E(1, MID, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, E(0, MID, 0, 0, 0, 0, 0)));
    tbl.push_back(R(1,  9, 0,  0, 0, 0, 0, 0, 0, E(1, UP,  0, 0, 0, 0, 0)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, E(0, UP, 0, 0, 0, 0, 0)));
    tbl.push_back(R(0,  0, 0,  0, 0, 0, 1, 0, 0, E(0, UP,  0, 1, 0, 0, 0)));
    tbl.push_back(R(0,  0, 0,  0, 0, 0, 0, 1, 0, E(0, UP,  0, 0, 0, 0, 0)));
    tbl.push_back(R(0,  0, 0,  0, 0, 0, 0, 0, 0, E(0, UP,  0, 1, 0, 0, 0)));
    tbl.push_back(R(1,  3, 0,  0, 0, 5, 1, 0, 0, E(0, UP,  1, 0, 1, 0, 0)));
    foreach (tbl[i]) do_frame(tbl[i]);

    hold_frames(1, 0, UP, 0);
    do_frame(R(1, 3, 0, 0, 0, 0, 0, 0, 0, E(1, UP, 0, 0, 1, 0, 0)));
    do_frame(R(0, 0, 0, 0, 3, 5, 0, 0, 0, E(0, UP, 1, 0, 1, 1, 0)));
    hold_frames(1, 1, UP, 0);
    do_frame(R(0, 0, 0, 0, 3, 3, 1, 0, 0, E(0, UP, 0, 1, 1, 1, 0)));
    for (int g = 2; g <= 5; g++) begin
      do_frame(R(0, 0, 0, 0, 0, 5, 0, 0, 0, E(0, UP, 1, 0, g, 1, 0)));
      hold_frames(g, 1, UP, g == 5);
    end
    repeat (2) do_frame(R(1, 3, 0, 0, 0, 5, 1, 0, 0, E(0, UP, 0, 0, 5, 1, 1)));

    set_move(0);
    set_move(0);
    set_move(1);
    do_frame(R(1, 3, 0, 0, 0, 0, 0, 0, 0, E(1, UP, 0, 0, 0, 0, 0)));
    do_frame(R(1, 3, 0, 0, 0, 0, 1, 0, 5, E(0, UP, 0, 0, 0, 0, 0)));
    set_move(1);
    do_frame(R(1, 25, 0, 0, 0, 0, 0, 0, 0, E(1, LOW, 0, 0, 0, 0, 0)));

    do_frame(R(0, 0, 0, 0, 0, 5, 0, 0, 0, E(0, LOW, 1, 0, 1, 0, 0)));
    for (int f = 0; f < 3; f++)
      do_frame(R(1, 3, 0, 0, 0, 0, 1, 0, 0, E(0, LOW, 0, 0, 1, 0, 0)));
    drive(0, 1, 1, 6'd3, 0, 0, 0);
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    chk("midhold_rst_outputs", int'({collision, X_direction, Y_direction, goal, doubleball, game_over}), 0);
    chk("midhold_rst_scoreL", int'(scoreL), 0);
    chk("midhold_rst_scoreR", int'(scoreR), 0);
    move = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    do_frame(R(1, 3, 0, 0, 0, 0, 0, 0, 0, E(0, MID, 0, 0, 0, 0, 0)));
    set_move(1);
    do_frame(R(1, 3, 0, 0, 0, 0, 0, 0, 0, E(1, UP, 0, 0, 0, 0, 0)));

    drive(0, 0, 0, 6'd0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
